// File: rtl/lsu_stage_pkg.sv
// Shared types for the load/store stage: EXU/WBU payloads, FSM states,
// memory-access funct3 encodings and a strobe helper.
package lsu_stage_pkg;

    // EXU -> LSU payload (139 bits).
    typedef struct packed {
        logic [31:0] pc_target;
        logic [31:0] exu_result;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [4:0]  rd_addr;
        logic        reg_wen;
        logic        mem_en;
        logic        mem_wen;
        logic [2:0]  funct3;
    } ex_lsu_t;

    // LSU -> WBU payload (70 bits).
    typedef struct packed {
        logic [31:0] wb_data;
        logic [31:0] pc_target;
        logic [4:0]  rd_addr;
        logic        reg_wen;
    } lsu_wb_t;

    // Fields of an accepted instruction still needed after the request phase.
    typedef struct packed {
        logic [31:0] pc_target;
        logic [31:0] exu_result;
        logic [4:0]  rd_addr;
        logic        reg_wen;
        logic        mem_wen;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
    } lsu_ctx_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRsp,
        StOut
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Unshifted byte strobes for an access size (funct3[1:0]).
    function automatic logic [3:0] lsu_base_strb(input logic [1:0] size);
        logic [3:0] strb;
        case (size)
            2'b00:   strb = 4'b0001;
            2'b01:   strb = 4'b0011;
            2'b10:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Bundle of the EXU input handshake, WBU output handshake, data-memory port
// and error pulses of the load/store stage.
interface lsu_stage_if
    import lsu_stage_pkg::*;
();

    logic        in_valid;
    logic        in_ready;
    ex_lsu_t     in_payload;

    logic        out_valid;
    logic        out_ready;
    lsu_wb_t     out_payload;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    logic        err_misalign;
    logic        err_bus;

    // The LSU side.
    modport slave (
        input  in_valid, in_payload, out_ready, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output in_ready, out_valid, out_payload, mem_req_valid, mem_req_wen, mem_req_addr,
        output mem_req_wdata, mem_req_wstrb, err_misalign, err_bus
    );

    // The surrounding pipeline and memory.
    modport master (
        output in_valid, in_payload, out_ready, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  in_ready, out_valid, out_payload, mem_req_valid, mem_req_wen, mem_req_addr,
        input  mem_req_wdata, mem_req_wstrb, err_misalign, err_bus
    );

endinterface

// File: rtl/lsu_stage_align.sv
// Combinational byte-lane logic: store strobe/data shifting, load extraction
// with sign/zero extension, and detection of illegal or misaligned accesses.
module lsu_align
    import lsu_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        bad_o
);

    logic [4:0]  lane_shift;
    logic [31:0] rdata_sh;

    assign lane_shift = {addr_lo_i, 3'b000};
    assign rdata_sh   = rdata_i >> lane_shift;

    // Decode legality/alignment and extend the addressed load lanes.
    always_comb begin
        bad_o   = 1'b0;
        rdata_o = 32'h0;
        case (funct3_i)
            LSU_B: begin
                rdata_o = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            end
            LSU_H: begin
                rdata_o = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
                bad_o   = addr_lo_i[0];
            end
            LSU_W: begin
                rdata_o = rdata_sh;
                bad_o   = |addr_lo_i;
            end
            LSU_BU: begin
                rdata_o = {24'h0, rdata_sh[7:0]};
                bad_o   = is_store_i;
            end
            LSU_HU: begin
                rdata_o = {16'h0, rdata_sh[15:0]};
                bad_o   = is_store_i | addr_lo_i[0];
            end
            default: begin
                bad_o = 1'b1;
            end
        endcase
    end

    // Store lane placement; loads carry no strobes and no data.
    always_comb begin
        wstrb_o = 4'h0;
        wdata_o = 32'h0;
        if (is_store_i) begin
            wstrb_o = lsu_base_strb(funct3_i[1:0]) << addr_lo_i;
            wdata_o = wdata_i << lane_shift;
        end
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: accepts one EXU payload at a time, runs a single
// outstanding data-memory transaction for loads/stores and hands the result
// to WBU. Non-memory instructions pass straight through.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input logic        clk,
    input logic        rst,
    lsu_stage_if.slave bus
);

    lsu_state_e  state_q, state_d;
    lsu_ctx_t    ctx_q, ctx_d;
    lsu_wb_t     out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic        req_valid_q, req_valid_d;
    logic        req_wen_q, req_wen_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic        err_mis_q, err_mis_d;
    logic        err_bus_q, err_bus_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    logic        idle;
    logic [2:0]  al_funct3;
    logic        al_store;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_bad;

    assign idle = (state_q == StIdle);

    // The aligner checks the incoming payload while idle and extracts load
    // data from the latched context while waiting for the response.
    assign al_funct3  = idle ? bus.in_payload.funct3       : ctx_q.funct3;
    assign al_store   = idle ? bus.in_payload.mem_wen      : ctx_q.mem_wen;
    assign al_addr_lo = idle ? bus.in_payload.mem_addr[1:0] : ctx_q.addr_lo;

    lsu_align u_align (
        .funct3_i   (al_funct3),
        .is_store_i (al_store),
        .addr_lo_i  (al_addr_lo),
        .wdata_i    (bus.in_payload.mem_wdata),
        .rdata_i    (bus.mem_rsp_rdata),
        .wstrb_o    (al_wstrb),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .bad_o      (al_bad)
    );

    // FSM next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        ctx_d       = ctx_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        req_valid_d = req_valid_q;
        req_wen_d   = req_wen_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        err_mis_d   = 1'b0;
        err_bus_d   = 1'b0;
        tmo_cnt_d   = tmo_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    ctx_d.pc_target  = bus.in_payload.pc_target;
                    ctx_d.exu_result = bus.in_payload.exu_result;
                    ctx_d.rd_addr    = bus.in_payload.rd_addr;
                    ctx_d.reg_wen    = bus.in_payload.reg_wen;
                    ctx_d.mem_wen    = bus.in_payload.mem_wen;
                    ctx_d.funct3     = bus.in_payload.funct3;
                    ctx_d.addr_lo    = bus.in_payload.mem_addr[1:0];
                    out_d.pc_target  = bus.in_payload.pc_target;
                    out_d.rd_addr    = bus.in_payload.rd_addr;
                    if (!bus.in_payload.mem_en) begin
                        out_d.wb_data = bus.in_payload.exu_result;
                        out_d.reg_wen = bus.in_payload.reg_wen;
                        out_valid_d   = 1'b1;
                        state_d       = StOut;
                    end else if (al_bad) begin
                        // Rejected access: no memory traffic, write-back suppressed.
                        out_d.wb_data = 32'h0;
                        out_d.reg_wen = 1'b0;
                        out_valid_d   = 1'b1;
                        err_mis_d     = 1'b1;
                        state_d       = StOut;
                    end else begin
                        req_valid_d = 1'b1;
                        req_wen_d   = bus.in_payload.mem_wen;
                        req_addr_d  = bus.in_payload.mem_addr;
                        req_wdata_d = al_wdata;
                        req_wstrb_d = al_wstrb;
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                if (bus.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    tmo_cnt_d   = 32'h0;
                    state_d     = StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (bus.mem_rsp_valid) begin
                    out_d.wb_data = ctx_q.mem_wen ? ctx_q.exu_result : al_rdata;
                    out_d.reg_wen = ctx_q.reg_wen;
                    out_valid_d   = 1'b1;
                    state_d       = StOut;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (tmo_cnt_q + 32'd1 == TIMEOUT_CYCLES) begin
                        out_d.wb_data = 32'h0;
                        out_d.reg_wen = 1'b0;
                        out_valid_d   = 1'b1;
                        err_bus_d     = 1'b1;
                        state_d       = StOut;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 32'd1;
                    end
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ctx_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            req_valid_q <= 1'b0;
            req_wen_q   <= 1'b0;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
            req_wstrb_q <= 4'h0;
            err_mis_q   <= 1'b0;
            err_bus_q   <= 1'b0;
            tmo_cnt_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            ctx_q       <= ctx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            req_valid_q <= req_valid_d;
            req_wen_q   <= req_wen_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            err_mis_q   <= err_mis_d;
            err_bus_q   <= err_bus_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign bus.in_ready      = idle;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_payload   = out_q;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_wen   = req_wen_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_req_wdata = req_wdata_q;
    assign bus.mem_req_wstrb = req_wstrb_q;
    assign bus.err_misalign  = err_mis_q;
    assign bus.err_bus       = err_bus_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: table of instructions with expected
// memory requests and write-back results, a scoreboard of expected WBU
// payloads, and a hand-written mid-transaction reset sequence.
module tb_lsu_stage;
    import lsu_stage_pkg::*;

    logic clk;
    logic rst;

    lsu_stage_if bus ();

    lsu_stage #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mem_en;
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exu;
        logic [4:0]  rd;
        logic        rwen;
        logic [31:0] rdata;
        int          rsp_delay;
        int          req_stall;
        int          out_stall;
        int          exp_req;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
        logic        exp_rwen;
        int          exp_mis;
        int          exp_bus;
    } vec_t;

    localparam int NumVec = 15;
    vec_t    vecs [NumVec];
    lsu_wb_t sb_q [$];
    int      n_checks = 0;
    int      n_fail   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic mem_en, input logic wen, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exu, input logic [4:0] rd, input logic rwen,
                                input logic [31:0] rdata, input int rsp_delay,
                                input int req_stall, input int out_stall, input int exp_req,
                                input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                                input logic [31:0] exp_wb, input logic exp_rwen,
                                input int exp_mis, input int exp_bus);
        vec_t v;
        v.mem_en = mem_en;     v.wen = wen;             v.f3 = f3;
        v.addr = addr;         v.wdata = wdata;         v.exu = exu;
        v.rd = rd;             v.rwen = rwen;           v.rdata = rdata;
        v.rsp_delay = rsp_delay; v.req_stall = req_stall; v.out_stall = out_stall;
        v.exp_req = exp_req;   v.exp_wstrb = exp_wstrb; v.exp_wdata = exp_wdata;
        v.exp_wb = exp_wb;     v.exp_rwen = exp_rwen;   v.exp_mis = exp_mis;
        v.exp_bus = exp_bus;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        ex_lsu_t     p;
        lsu_wb_t     exp_out;
        lsu_wb_t     out_snap;
        lsu_wb_t     exp_pop;
        logic [68:0] req_snap;
        string       tag;
        int          req_hs, hs_cyc, mis_n, bus_n, mis_cyc, bus_cyc, out_cyc;
        int          req_stall, out_stall, done, stable_bad, req_seen, out_seen;
        int          pend_req, pend_out;

        tag = $sformatf("v%0d", idx);
        p = '0;
        p.pc_target  = 32'h1000 + idx * 4;
        p.exu_result = v.exu;
        p.mem_addr   = v.addr;
        p.mem_wdata  = v.wdata;
        p.rd_addr    = v.rd;
        p.reg_wen    = v.rwen;
        p.mem_en     = v.mem_en;
        p.mem_wen    = v.wen;
        p.funct3     = v.f3;

        exp_out.wb_data   = v.exp_wb;
        exp_out.pc_target = p.pc_target;
        exp_out.rd_addr   = v.rd;
        exp_out.reg_wen   = v.exp_rwen;
        sb_q.push_back(exp_out);

        check({tag, " in_ready"}, bus.in_ready, 1);
        bus.in_payload = p;
        bus.in_valid   = 1'b1;
        step();
        bus.in_valid   = 1'b0;
        bus.in_payload = '0;

        req_hs = 0; hs_cyc = -1; mis_n = 0; bus_n = 0; mis_cyc = -1; bus_cyc = -1;
        out_cyc = -1; req_stall = v.req_stall; out_stall = v.out_stall; done = 0;
        stable_bad = 0; req_seen = 0; out_seen = 0; pend_req = 0; pend_out = 0;
        req_snap = '0; out_snap = '0;

        for (int c = 0; c < 30 && done == 0; c++) begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_req_ready = 1'b0;
            bus.out_ready     = 1'b0;
            if (pend_req != 0) begin
                pend_req = 0;
                req_hs++;
                hs_cyc = c;
            end
            if (pend_out != 0) begin
                done = 1;
                check({tag, " out_drop"}, {bus.out_valid, bus.in_ready}, 2'b01);
            end else begin
                if (bus.err_misalign) begin mis_n++; mis_cyc = c; end
                if (bus.err_bus) begin bus_n++; bus_cyc = c; end
                if (bus.mem_req_valid) begin
                    if (req_seen == 0) begin
                        req_seen = 1;
                        req_snap = {bus.mem_req_wen, bus.mem_req_addr, bus.mem_req_wdata,
                                    bus.mem_req_wstrb};
                        check({tag, " req_wen"}, bus.mem_req_wen, v.wen);
                        check({tag, " req_addr"}, bus.mem_req_addr, v.addr);
                        check({tag, " req_wdata"}, bus.mem_req_wdata, v.exp_wdata);
                        check({tag, " req_wstrb"}, bus.mem_req_wstrb, v.exp_wstrb);
                    end else if ({bus.mem_req_wen, bus.mem_req_addr, bus.mem_req_wdata,
                                  bus.mem_req_wstrb} !== req_snap) begin
                        stable_bad = 1;
                    end
                    if (req_stall > 0) begin
                        req_stall--;
                    end else begin
                        bus.mem_req_ready = 1'b1;
                        pend_req = 1;
                    end
                end
                if (hs_cyc >= 0 && c - hs_cyc == v.rsp_delay) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_rdata = v.rdata;
                end
                if (bus.out_valid) begin
                    if (out_seen == 0) begin
                        out_seen = 1;
                        out_cyc  = c;
                        out_snap = bus.out_payload;
                    end else if (bus.out_payload !== out_snap) begin
                        stable_bad = 1;
                    end
                    if (out_stall > 0) begin
                        out_stall--;
                    end else begin
                        bus.out_ready = 1'b1;
                        pend_out = 1;
                        exp_pop = sb_q.pop_front();
                        check({tag, " out_payload"}, bus.out_payload, exp_pop);
                    end
                end
            end
            if (done == 0) step();
        end
        bus.out_ready     = 1'b0;
        bus.mem_rsp_valid = 1'b0;

        check({tag, " completed"}, done, 1);
        if (sb_q.size() != 0) sb_q.delete();
        check({tag, " req_count"}, req_hs, v.exp_req);
        check({tag, " req_seen"}, req_seen, v.exp_req);
        check({tag, " err_misalign"}, mis_n, v.exp_mis);
        check({tag, " err_bus"}, bus_n, v.exp_bus);
        check({tag, " stable"}, stable_bad, 0);
        if (v.mem_en == 1'b0 || v.exp_mis != 0) check({tag, " out_latency"}, out_cyc, 0);
        if (v.exp_mis != 0) check({tag, " mis_cycle"}, mis_cyc, 0);
        if (v.exp_bus != 0) check({tag, " bus_delay"}, bus_cyc - hs_cyc, 4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ex_lsu_t p;
        int      seen_out;
        int      not_ready;

        vecs[0]  = mk(1'b0, 1'b0, LSU_B, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b1, 32'h0,
                      -1, 0, 0, 0, 4'h0, 32'h0, 32'h1234_5678, 1'b1, 0, 0);
        vecs[1]  = mk(1'b1, 1'b0, LSU_B, 32'h8000_0003, 32'h0, 32'h8000_0003, 5'd7, 1'b1,
                      32'h80FF_0000, 1, 0, 0, 1, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b1, 0, 0);
        vecs[2]  = mk(1'b1, 1'b0, LSU_BU, 32'h8000_0003, 32'h0, 32'h8000_0003, 5'd8, 1'b1,
                      32'h80FF_0000, 0, 0, 0, 1, 4'h0, 32'h0, 32'h0000_0080, 1'b1, 0, 0);
        vecs[3]  = mk(1'b1, 1'b1, LSU_H, 32'h8000_0002, 32'h0000_ABCD, 32'h8000_0002, 5'd0,
                      1'b0, 32'h0, 1, 0, 0, 1, 4'hC, 32'hABCD_0000, 32'h8000_0002, 1'b0, 0, 0);
        vecs[4]  = mk(1'b1, 1'b0, LSU_W, 32'h8000_0004, 32'h0, 32'h8000_0004, 5'd9, 1'b1,
                      32'hCAFE_F00D, 2, 3, 2, 1, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b1, 0, 0);
        vecs[5]  = mk(1'b1, 1'b0, LSU_W, 32'h8000_0001, 32'h0, 32'h8000_0001, 5'd10, 1'b1,
                      32'h0, -1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1'b0, 1, 0);
        vecs[6]  = mk(1'b1, 1'b0, LSU_H, 32'h8000_0002, 32'h0, 32'h8000_0002, 5'd11, 1'b1,
                      32'h8001_1234, 0, 0, 0, 1, 4'h0, 32'h0, 32'hFFFF_8001, 1'b1, 0, 0);
        vecs[7]  = mk(1'b1, 1'b0, LSU_HU, 32'h8000_0000, 32'h0, 32'h8000_0000, 5'd12, 1'b1,
                      32'h1234_F00F, 0, 1, 1, 1, 4'h0, 32'h0, 32'h0000_F00F, 1'b1, 0, 0);
        vecs[8]  = mk(1'b1, 1'b1, LSU_B, 32'h8000_0001, 32'h0000_00AB, 32'h55, 5'd13, 1'b1,
                      32'h0, 2, 0, 0, 1, 4'h2, 32'h0000_AB00, 32'h55, 1'b1, 0, 0);
        vecs[9]  = mk(1'b1, 1'b1, LSU_W, 32'h8000_0008, 32'h1122_3344, 32'h77, 5'd14, 1'b0,
                      32'h0, 0, 0, 0, 1, 4'hF, 32'h1122_3344, 32'h77, 1'b0, 0, 0);
        vecs[10] = mk(1'b1, 1'b0, LSU_H, 32'h3, 32'h0, 32'h3, 5'd15, 1'b1,
                      32'h0, -1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1'b0, 1, 0);
        vecs[11] = mk(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 5'd16, 1'b1,
                      32'h0, -1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1'b0, 1, 0);
        vecs[12] = mk(1'b1, 1'b1, 3'b100, 32'h0, 32'hFF, 32'h0, 5'd17, 1'b1,
                      32'h0, -1, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1'b0, 1, 0);
        vecs[13] = mk(1'b1, 1'b0, LSU_W, 32'h10, 32'h0, 32'h10, 5'd18, 1'b1,
                      32'h0, -1, 0, 0, 1, 4'h0, 32'h0, 32'h0, 1'b0, 0, 1);
        vecs[14] = mk(1'b1, 1'b0, LSU_B, 32'h1, 32'h0, 32'h1, 5'd19, 1'b1,
                      32'h0000_7F00, 0, 0, 0, 1, 4'h0, 32'h0, 32'h0000_007F, 1'b1, 0, 0);

        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_payload    = '0;
        bus.out_ready     = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;
        step();
        step();
        rst = 1'b0;
        step();

        check("reset in_ready", bus.in_ready, 1);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_payload", bus.out_payload, 0);
        check("reset mem_req", {bus.mem_req_valid, bus.mem_req_wen, bus.mem_req_addr,
                                bus.mem_req_wdata, bus.mem_req_wstrb}, 0);
        check("reset errors", {bus.err_misalign, bus.err_bus}, 0);

        for (int i = 0; i < NumVec; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while waiting for a response, then a stale response arrives.
        p = '0;
        p.mem_en   = 1'b1;
        p.funct3   = LSU_W;
        p.mem_addr = 32'h40;
        p.rd_addr  = 5'd3;
        p.reg_wen  = 1'b1;
        bus.in_payload = p;
        bus.in_valid   = 1'b1;
        step();
        bus.in_valid   = 1'b0;
        bus.in_payload = '0;
        check("rst_seq req_valid", bus.mem_req_valid, 1);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        check("rst_seq waiting", {bus.mem_req_valid, bus.in_ready, bus.out_valid}, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_seq async in_ready", bus.in_ready, 1);
        step();
        rst = 1'b0;
        bus.out_ready     = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'hBAD0_BAD0;
        step();
        bus.mem_rsp_valid = 1'b0;
        seen_out  = 0;
        not_ready = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid) seen_out++;
            if (!bus.in_ready) not_ready++;
            step();
        end
        bus.out_ready = 1'b0;
        check("rst_seq no out_valid", seen_out, 0);
        check("rst_seq in_ready held", not_ready, 0);
        check("scoreboard empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
